// File: rtl/fsm_s2_pulse_gen_pkg.sv
// Shared definitions for the FSM_S2 pulse generator: state encodings and the
// default pulse count that the detector and benches also rely on.
package fsm_s2_pulse_gen_pkg;

  // Number of high pulses the FSM_S2 detector needs to walk Idle -> Idle
  localparam int unsigned FSM_S2_PULSES = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HIGH     = 3'd1,
    S_LOW      = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Every state except IDLE counts as part of a transaction
  function automatic logic is_busy_state(input state_t s);
    return (s != S_IDLE);
  endfunction

endpackage

// File: rtl/fsm_s2_pulse_gen_cyc_timer.sv
// Loadable up-counter with an expire flag. The flag is raised during the last
// enabled cycle of a window of 'limit' cycles, counted from the most recent load.
module fsm_s2_pulse_gen_cyc_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; a load restarts the window at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = en && (count == (limit - CNT_W'(1)));

endmodule

// File: rtl/fsm_s2_pulse_gen.sv
// Transmitter for the FSM_S2 pulse-sequence protocol. A start request produces
// a fixed train of high pulses on line_out, then the block waits for the
// detector acknowledge (or a timeout) and strobes done.
module fsm_s2_pulse_gen
  import fsm_s2_pulse_gen_pkg::*;
#(
  parameter int unsigned PULSES   = FSM_S2_PULSES,
  parameter int unsigned HIGH_CYC = 1,
  parameter int unsigned LOW_CYC  = 1,
  parameter int unsigned TIMEOUT  = 8,
  parameter int          CNT_W    = 8
) (
  input  logic Clk,
  input  logic rst,
  input  logic start,
  input  logic ack_in,
  output logic line_out,
  output logic busy,
  output logic done,
  output logic timeout_err
);

  localparam logic [CNT_W-1:0] HIGH_LIM  = CNT_W'(HIGH_CYC);
  localparam logic [CNT_W-1:0] LOW_LIM   = CNT_W'(LOW_CYC);
  localparam logic [CNT_W-1:0] TO_LIM    = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PULSES_M1 = CNT_W'(PULSES - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] pulse_cnt;
  logic [CNT_W-1:0] phase_limit;
  logic             phase_load;
  logic             phase_en;
  logic             phase_exp;
  logic             to_load;
  logic             to_en;
  logic             to_exp;
  logic             start_accept;
  logic             set_err;
  logic             pulse_inc;

  // Phase timer restarts on every HIGH/LOW entry and measures the active phase
  assign phase_limit = (state == S_HIGH) ? HIGH_LIM : LOW_LIM;
  assign phase_load  = (state_next != state);
  assign phase_en    = (state == S_HIGH) || (state == S_LOW);

  // Timeout timer is held clear outside WAIT_ACK so it starts fresh on entry
  assign to_load = (state != S_WAIT_ACK);
  assign to_en   = (state == S_WAIT_ACK);

  fsm_s2_pulse_gen_cyc_timer #(.CNT_W(CNT_W)) u_phase_timer (
    .clk     (Clk),
    .rst     (rst),
    .load    (phase_load),
    .en      (phase_en),
    .limit   (phase_limit),
    .expired (phase_exp)
  );

  fsm_s2_pulse_gen_cyc_timer #(.CNT_W(CNT_W)) u_timeout_timer (
    .clk     (Clk),
    .rst     (rst),
    .load    (to_load),
    .en      (to_en),
    .limit   (TO_LIM),
    .expired (to_exp)
  );

  // Next-state logic; ack wins over a timeout expiring in the same cycle
  always_comb begin
    state_next   = state;
    start_accept = 1'b0;
    set_err      = 1'b0;
    pulse_inc    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next   = S_HIGH;
          start_accept = 1'b1;
        end
      end
      S_HIGH: begin
        if (phase_exp) state_next = S_LOW;
      end
      S_LOW: begin
        if (phase_exp) begin
          pulse_inc = 1'b1;
          if (pulse_cnt == PULSES_M1) state_next = S_WAIT_ACK;
          else                        state_next = S_HIGH;
        end
      end
      S_WAIT_ACK: begin
        if (ack_in) begin
          state_next = S_DONE;
        end else if (to_exp) begin
          state_next = S_DONE;
          set_err    = 1'b1;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Pulse counter: cleared on an accepted start, bumped at the end of each LOW
  always_ff @(posedge Clk) begin
    if (rst) begin
      pulse_cnt <= '0;
    end else if (start_accept) begin
      pulse_cnt <= '0;
    end else if (pulse_inc) begin
      pulse_cnt <= pulse_cnt + CNT_W'(1);
    end
  end

  // Registered outputs decoded from the state being entered
  always_ff @(posedge Clk) begin
    if (rst) begin
      line_out <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      line_out <= (state_next == S_HIGH);
      busy     <= is_busy_state(state_next);
      done     <= (state_next == S_DONE);
    end
  end

  // Sticky timeout flag, cleared only when a new transaction is accepted
  always_ff @(posedge Clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (start_accept) begin
      timeout_err <= 1'b0;
    end else if (set_err) begin
      timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fsm_s2_pulse_gen.sv
// Bench for fsm_s2_pulse_gen: a cycle-by-cycle vector table for the default
// configuration plus hand-written sequences for reset and a parameter override.
module tb_fsm_s2_pulse_gen;
  import fsm_s2_pulse_gen_pkg::*;

  typedef struct packed {
    logic start;
    logic ack_in;
    logic rst;
    logic line_out;
    logic busy;
    logic done;
    logic timeout_err;
  } vec_t;

  logic Clk = 1'b0;
  logic rst, start, ack_in;
  logic line_out, busy, done, timeout_err;
  logic rst2, start2, ack2;
  logic line2, busy2, done2, err2;

  int   total = 0;
  int   bad   = 0;
  vec_t vecs[$];

  always #5 Clk = ~Clk;

  fsm_s2_pulse_gen dut (
    .Clk         (Clk),
    .rst         (rst),
    .start       (start),
    .ack_in      (ack_in),
    .line_out    (line_out),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  fsm_s2_pulse_gen #(.PULSES(2), .HIGH_CYC(2), .LOW_CYC(3)) dut2 (
    .Clk         (Clk),
    .rst         (rst2),
    .start       (start2),
    .ack_in      (ack2),
    .line_out    (line2),
    .busy        (busy2),
    .done        (done2),
    .timeout_err (err2)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic addVec(input logic s, input logic a, input logic r,
                        input logic l, input logic b, input logic d, input logic e);
    vec_t v;
    v.start = s; v.ack_in = a; v.rst = r;
    v.line_out = l; v.busy = b; v.done = d; v.timeout_err = e;
    vecs.push_back(v);
  endtask

  // Full default train from IDLE: start on the first edge, then held inputs
  task automatic addTrain(input logic s_hold, input logic a_hold);
    for (int i = 0; i < 2 * FSM_S2_PULSES; i++)
      addVec((i == 0) ? 1'b1 : s_hold, a_hold, 1'b0, (i % 2 == 0), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge Clk);
    start  = v.start;
    ack_in = v.ack_in;
    rst    = v.rst;
    @(posedge Clk);
    #1;
  endtask

  task automatic tick2(input logic s);
    @(negedge Clk);
    start2 = s;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    logic [9:0] line_pat;
    int         n;

    // Basic train with ack two cycles after WAIT_ACK entry
    addTrain(1'b0, 1'b0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 1, 0, 0, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);
    // Stray start/ack during the train, then no ack -> timeout
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(1, 0, 0, 0, 1, 0, 0);
    addVec(1, 1, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 1, 0, 1, 1, 0, 0);
    for (int i = 5; i < 10; i++) addVec(0, 0, 0, (i % 2 == 0), 1, 0, 0);
    for (int i = 0; i < 8; i++)  addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 1, 1);
    addVec(1, 0, 0, 0, 0, 0, 1);
    addVec(0, 0, 0, 0, 0, 0, 1);
    // New start clears the error; reset after the third pulse
    addVec(1, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 0, 0, 0, 0);
    addTrain(1'b0, 1'b0);
    addVec(0, 0, 0, 0, 1, 0, 0);
    addVec(0, 1, 0, 0, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);
    // Start and ack held high: back-to-back trains with one IDLE cycle
    addTrain(1'b1, 1'b1);
    addVec(1, 1, 0, 0, 1, 0, 0);
    addVec(1, 1, 0, 0, 1, 1, 0);
    addVec(1, 1, 0, 0, 0, 0, 0);
    addTrain(1'b1, 1'b1);
    addVec(1, 1, 0, 0, 1, 0, 0);
    addVec(1, 1, 0, 0, 1, 1, 0);
    addVec(0, 0, 0, 0, 0, 0, 0);

    // Reset with start asserted: reset must win
    rst = 1'b1; start = 1'b1; ack_in = 1'b0;
    rst2 = 1'b1; start2 = 1'b1; ack2 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checkOutput("reset line_out", line_out, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset timeout_err", timeout_err, 0);
    checkOutput("reset dut2 busy", busy2, 0);
    @(negedge Clk);
    rst = 1'b0; start = 1'b0; rst2 = 1'b0; start2 = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d line_out", i), line_out, vecs[i].line_out);
      checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      checkOutput($sformatf("vec%0d done", i), done, vecs[i].done);
      checkOutput($sformatf("vec%0d timeout_err", i), timeout_err, vecs[i].timeout_err);
    end

    // Override PULSES=2 HIGH_CYC=2 LOW_CYC=3, no ack -> timeout after 8 cycles
    line_pat = 10'b11000_11000;
    for (int i = 0; i < 10; i++) begin
      tick2(i == 0);
      checkOutput($sformatf("ovr line_out c%0d", i + 1), line2, line_pat[9 - i]);
      checkOutput($sformatf("ovr busy c%0d", i + 1), busy2, 1);
    end
    tick2(1'b0);
    checkOutput("ovr wait line_out", line2, 0);
    checkOutput("ovr wait busy", busy2, 1);
    checkOutput("ovr wait done", done2, 0);
    n = 0;
    while (n <= 20 && done2 !== 1'b1) begin
      tick2(1'b0);
      n++;
    end
    checkOutput("ovr cycles to done", n, 8);
    checkOutput("ovr timeout_err", err2, 1);
    tick2(1'b0);
    checkOutput("ovr idle busy", busy2, 0);
    checkOutput("ovr sticky err", err2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fsm_s2_pulse_gen.md
Name: fsm_s2_pulse_gen

Overview:
Transmitter side of the FSM_S2 pulse-sequence protocol. On a start request it drives a serial line with a fixed train of PULSES high pulses, separated by low gaps. The train is exactly what the FSM_S2 detector needs to walk from Idle back to Idle. The block then waits for the detector's FSM_out acknowledge, or times out, and reports completion. It sits upstream of FSM_S2, and its line_out connects directly to FSM_in.

Parameters:
PULSES, 5, number of high pulses per transaction (>=1)
HIGH_CYC, 1, cycles each pulse is held high (>=1)
LOW_CYC, 1, cycles of low gap after each pulse (>=1)
TIMEOUT, 8, max cycles in WAIT_ACK before error (>=1)
CNT_W, 8, width of the pulse, phase and timeout counters; must hold max(PULSES, HIGH_CYC, LOW_CYC, TIMEOUT)

Ports:
Clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  transaction request; sampled only in IDLE
ack_in  input  1  acknowledge from detector (FSM_out)
line_out  output  1  serial pulse line to detector FSM_in
busy  output  1  high from HIGH entry until DONE exit
done  output  1  one-cycle completion strobe
timeout_err  output  1  sticky error; set on timeout, cleared on next accepted start

Behaviour:
- Clocking: one clock (Clk); reset rst is synchronous and active-high. All outputs are registered.
- Reset values: line_out=0, busy=0, done=0, timeout_err=0, state=IDLE, all counters=0.
- States: IDLE, HIGH, LOW, WAIT_ACK, DONE.
- IDLE: line_out=0. If start=1 at edge k:
  - enter HIGH; line_out=1 and busy=1 from cycle k+1;
  - clear timeout_err and the pulse counter.
- HIGH: hold line_out=1 for HIGH_CYC cycles, then go to LOW.
- LOW: hold line_out=0 for LOW_CYC cycles. At the end of the phase, increment the pulse counter:
  - if count==PULSES, go to WAIT_ACK;
  - otherwise go to HIGH.
- Pulse train length: exactly PULSES*(HIGH_CYC+LOW_CYC) cycles.
- WAIT_ACK: line_out=0; the timeout counter increments each cycle.
  - If ack_in=1, go to DONE.
  - Otherwise, after TIMEOUT cycles in WAIT_ACK, go to DONE and set timeout_err=1.
  - If ack_in=1 in the same cycle the timeout expires, ack wins and timeout_err stays 0.
- DONE: single cycle with done=1 and busy=1, then return to IDLE. busy drops in the IDLE cycle.
- start outside IDLE is ignored, including during DONE. No queuing.
- With start held high, back-to-back transactions are separated by exactly one IDLE cycle.
- ack_in outside WAIT_ACK is ignored, with no error.
- Reset mid-operation: next cycle line_out=0, busy=0, done=0, timeout_err=0, state=IDLE. No partial pulse is extended.
- Counters saturate-free: they are compared against parameters and cleared on each phase entry. No wrap occurs within legal parameters.

Decomposition:
- Shared header fsm_s2_defs.vh holds:
  - state encodings (IDLE=3'd0, HIGH=3'd1, LOW=3'd2, WAIT_ACK=3'd3, DONE=3'd4);
  - the default PULSES value, also used by the detector and benches.
- One sub-module, fsm_s2_cyc_timer: a loadable CNT_W-bit counter with an expire flag. It is instantiated twice: once for phase length (HIGH/LOW) and once for the WAIT_ACK timeout.
- The pulse counter stays inline in the top.

Test Plan:
- Defaults, start pulse at cycle 0, ack_in asserted 2 cycles after WAIT_ACK entry:
  - line_out = 1,0,1,0,1,0,1,0,1,0 on cycles 1-10;
  - done=1 on cycle 13, timeout_err=0, busy low on cycle 14.
- Defaults, ack_in never asserted:
  - WAIT_ACK occupies cycles 11-18;
  - done=1 and timeout_err=1 on cycle 19;
  - timeout_err stays 1 until the next start, cleared the cycle after that start is accepted.
- rst=1 for one cycle after the 3rd pulse:
  - line_out=0 and busy=0 the next cycle;
  - a new start produces all 5 pulses, not 2.
- PULSES=2, HIGH_CYC=2, LOW_CYC=3 override:
  - line_out = 1,1,0,0,0,1,1,0,0,0;
  - then WAIT_ACK.
- start held high continuously with ack_in tied to FSM_S2.FSM_out (closed loop with the detector):
  - repeated transactions, each ending with done=1, no timeouts;
  - one IDLE cycle between trains.
- start asserted during HIGH/LOW/DONE, and ack_in pulsed during LOW:
  - no effect on train length;
  - no early DONE.
